// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared encodings for the Pac-Man direction input stage.
//   dir_e        : 2-bit heading encoding (U=0, D=1, L=2, R=3)
//   state_e      : direction-controller FSM states (IDLE=0, MOVE=1, STALL=2)
//   OH_*         : one-hot output patterns, bit order {right, left, down, up}
//   dir_to_onehot: converts a heading to its one-hot output pattern
// -----------------------------------------------------------------------------
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    localparam logic [3:0] OH_NONE = 4'b0000;
    localparam logic [3:0] OH_U    = 4'b0001;
    localparam logic [3:0] OH_D    = 4'b0010;
    localparam logic [3:0] OH_L    = 4'b0100;
    localparam logic [3:0] OH_R    = 4'b1000;

    function automatic logic [3:0] dir_to_onehot(input dir_e dir);
        logic [3:0] oh;
        case (dir)
            DIR_U:   oh = OH_U;
            DIR_D:   oh = OH_D;
            DIR_L:   oh = OH_L;
            DIR_R:   oh = OH_R;
            default: oh = OH_NONE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pacman_dir_ctrl_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser, stability counter and rising-edge press pulse for one
// raw push button.
//   clk, rst  : master clock, asynchronous active-high reset
//   btn_raw   : raw asynchronous button input
//   press     : one-clk pulse, high in the cycle the debounced level rises
// Parameter DEBOUNCE_CYCLES: clk cycles the synchronised level must differ
// from the debounced level before the debounced level follows it.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Register stage: synchroniser, debounced level, counter and press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreement (a glitch ending) restarts it from zero.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pacman_dir_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_dir_ctrl
// Input stage for the Pac-Man block controller. Debounces the four direction
// buttons, buffers one turn request and commits turns on move ticks when the
// legal-move checker allows them.
//   clk, rst                  : master clock, asynchronous active-high reset
//   btn_u/d/l/r               : raw asynchronous direction buttons
//   legal_u/d/l/r             : legal-move flags, sampled while move_tick is high
//   frame_start               : per-frame pulse, only used as the tick source
//                               when PACMAN_DIR_FRAME_TICK_EN is defined
//   up/down/left/right        : held one-hot heading, all zero unless moving
//   move_tick                 : one-clk movement step strobe
//   pend_valid                : a buffered turn request is waiting
//   state_o                   : FSM state (IDLE=0, MOVE=1, STALL=2)
// Build option: define PACMAN_DIR_FRAME_TICK_EN to take move_tick from
// frame_start (delayed one clk) instead of the internal TICK_DIV divider.
// -----------------------------------------------------------------------------
module pacman_dir_ctrl
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 2_000_000,
    parameter int PEND_TICKS      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       legal_u,
    input  logic       legal_d,
    input  logic       legal_l,
    input  logic       legal_r,
    input  logic       frame_start,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       move_tick,
    output logic       pend_valid,
    output logic [1:0] state_o
);

    localparam int PEND_W = (PEND_TICKS > 1) ? $clog2(PEND_TICKS) : 1;
    localparam logic [PEND_W-1:0] PEND_LAST = PEND_W'(PEND_TICKS - 1);

    logic [3:0] btn_vec;
    logic [3:0] press_vec;
    logic [3:0] legal_vec;

    logic              press_any;
    dir_e              press_dir;
    logic              pend_hit;
    logic              commit;

    state_e            state_q,      state_d;
    dir_e              cur_q,        cur_d;
    dir_e              pend_dir_q,   pend_dir_d;
    logic              pend_valid_q, pend_valid_d;
    logic [PEND_W-1:0] pend_age_q,   pend_age_d;
    logic [3:0]        dir_oh_q,     dir_oh_d;
    logic              move_tick_q,  move_tick_d;

    // Vectors are indexed by dir_e so legal_vec[dir] picks the matching flag.
    assign btn_vec   = {btn_r, btn_l, btn_d, btn_u};
    assign legal_vec = {legal_r, legal_l, legal_d, legal_u};

    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_vec[i]),
            .press   (press_vec[i])
        );
    end

`ifdef PACMAN_DIR_FRAME_TICK_EN
    // Movement steps follow the VGA frame rate, one clk behind frame_start.
    always_comb begin
        move_tick_d = frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_tick_q <= 1'b0;
        end else begin
            move_tick_q <= move_tick_d;
        end
    end
`else
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              unused_frame_start;

    assign unused_frame_start = frame_start;

    // Free-running divider; the strobe is registered so it fires in the cycle
    // after the counter wraps.
    always_comb begin
        move_tick_d = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = move_tick_d ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            move_tick_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            move_tick_q <= move_tick_d;
        end
    end
`endif

    // Simultaneous presses resolve U > D > L > R.
    always_comb begin
        press_any = |press_vec;
        if (press_vec[0]) begin
            press_dir = DIR_U;
        end else if (press_vec[1]) begin
            press_dir = DIR_D;
        end else if (press_vec[2]) begin
            press_dir = DIR_L;
        end else begin
            press_dir = DIR_R;
        end
    end

    // State register: FSM state, heading, pending request and output levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= DIR_U;
            pend_dir_q   <= DIR_U;
            pend_valid_q <= 1'b0;
            pend_age_q   <= '0;
            dir_oh_q     <= OH_NONE;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            pend_age_q   <= pend_age_d;
            dir_oh_q     <= dir_oh_d;
        end
    end

    // Next-state logic. Only the pending value registered before the tick is
    // considered, so a press landing on the tick waits for the next one.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        commit   = 1'b0;
        pend_hit = pend_valid_q && legal_vec[pend_dir_q];
        if (move_tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_hit) begin
                        cur_d   = pend_dir_q;
                        commit  = 1'b1;
                        state_d = ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (pend_hit) begin
                        cur_d  = pend_dir_q;
                        commit = 1'b1;
                    end else if (!legal_vec[cur_q]) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (pend_hit) begin
                        cur_d   = pend_dir_q;
                        commit  = 1'b1;
                        state_d = ST_MOVE;
                    end else if (legal_vec[cur_q]) begin
                        state_d = ST_MOVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pending request: a new press always wins; otherwise each tick either
    // consumes the request or ages it until it expires.
    always_comb begin
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        pend_age_d   = pend_age_q;
        if (press_any) begin
            pend_dir_d   = press_dir;
            pend_valid_d = 1'b1;
            pend_age_d   = '0;
        end else if (move_tick_q && pend_valid_q) begin
            if (commit || (pend_age_q == PEND_LAST)) begin
                pend_valid_d = 1'b0;
                pend_age_d   = '0;
            end else begin
                pend_age_d = pend_age_q + 1'b1;
            end
        end
    end

    // Output logic: levels are computed from the next state so the registered
    // heading changes exactly one clk after the committing tick.
    always_comb begin
        dir_oh_d = (state_d == ST_MOVE) ? dir_to_onehot(cur_d) : OH_NONE;
    end

    assign up         = dir_oh_q[0];
    assign down       = dir_oh_q[1];
    assign left       = dir_oh_q[2];
    assign right      = dir_oh_q[3];
    assign move_tick  = move_tick_q;
    assign pend_valid = pend_valid_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pacman_dir_ctrl
// Scoreboard bench for pacman_dir_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8,
// PEND_TICKS=3. Each stimulus step covers one move tick and queues the
// outputs expected one clk after that tick; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pacman_dir_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 8;
    localparam int PEND = 3;

    localparam logic [3:0] N = 4'b0000;
    localparam logic [3:0] U = 4'b0001;
    localparam logic [3:0] D = 4'b0010;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] R = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_u, btn_d, btn_l, btn_r;
    logic       legal_u, legal_d, legal_l, legal_r;
    logic       frame_start;
    logic       up, down, left, right;
    logic       move_tick;
    logic       pend_valid;
    logic [1:0] state_o;

    typedef struct {
        int         id;
        logic [3:0] oh;
        logic [1:0] st;
        logic       pv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pacman_dir_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV),
        .PEND_TICKS     (PEND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .legal_u    (legal_u),
        .legal_d    (legal_d),
        .legal_l    (legal_l),
        .legal_r    (legal_r),
        .frame_start(frame_start),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .move_tick  (move_tick),
        .pend_valid (pend_valid),
        .state_o    (state_o)
    );

    task automatic checkOutput(input string name, input logic [3:0] exp_oh,
                               input logic [1:0] exp_st, input logic exp_pv,
                               input bit chk_pv);
        logic [3:0] act_oh;
        act_oh = {right, left, down, up};
        checks++;
        if (act_oh !== exp_oh || state_o !== exp_st || (chk_pv && pend_valid !== exp_pv)) begin
            errors++;
            $display("[TB] FAIL %s: got oh(rldu)=%b state=%0d pend=%b, want oh=%b state=%0d pend=%b",
                     name, act_oh, state_o, pend_valid, exp_oh, exp_st, exp_pv);
        end
    endtask

    task automatic setInputs(input logic [3:0] b, input logic [3:0] l);
        {btn_r, btn_l, btn_d, btn_u}         = b;
        {legal_r, legal_l, legal_d, legal_u} = l;
    endtask

    // Returns at the negedge one clk after a move_tick was seen.
    task automatic waitTick();
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4 * TDIV) begin
            @(negedge clk);
            n++;
            seen = (move_tick === 1'b1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: no move_tick within %0d clk, want one", 4 * TDIV);
        end
        @(negedge clk);
    endtask

    task automatic pushExp(input int id, input logic [3:0] oh, input logic [1:0] st,
                           input logic pv);
        exp_t e;
        e.id = id;
        e.oh = oh;
        e.st = st;
        e.pv = pv;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] b, input logic [3:0] l,
                                 input logic [3:0] oh, input logic [1:0] st, input logic pv);
        setInputs(b, l);
        pushExp(id, oh, st, pv);
        waitTick();
    endtask

    // Monitor: at every tick the outputs must still hold the previous result,
    // and one clk later they must match the queued expectation.
    initial begin
        int         cyc;
        int         last_tick;
        bit         have_last;
        logic [3:0] last_oh;
        logic [1:0] last_st;
        exp_t       e;
        cyc       = 0;
        last_tick = 0;
        have_last = 1'b0;
        last_oh   = N;
        last_st   = 2'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (move_tick === 1'b1 && exp_q.size() > 0) begin
                if (have_last) begin
                    checks++;
                    if (cyc - last_tick != TDIV) begin
                        errors++;
                        $display("[TB] FAIL tick_period: got %0d clk, want %0d", cyc - last_tick, TDIV);
                    end
                end
                last_tick = cyc;
                have_last = 1'b1;
                checkOutput("hold_at_tick", last_oh, last_st, 1'b0, 1'b0);
                @(negedge clk);
                cyc++;
                e = exp_q.pop_front();
                checkOutput($sformatf("step%0d", e.id), e.oh, e.st, e.pv, 1'b1);
                last_oh = e.oh;
                last_st = e.st;
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        setInputs(N, N);
        repeat (3) @(negedge clk);
        checkOutput("reset_state", N, 2'd0, 1'b0, 1'b1);
        rst = 1'b0;
        waitTick();

        // 3-clk glitch on btn_r must not create a request
        setInputs(N, N);
        pushExp(1, N, 2'd0, 1'b0);
        btn_r = 1'b1;
        repeat (3) @(negedge clk);
        btn_r = 1'b0;
        waitTick();

        applyStimulus(2,  R,     R,     R, 2'd1, 1'b0);
        applyStimulus(3,  N,     R,     R, 2'd1, 1'b0);
        applyStimulus(4,  U,     R,     R, 2'd1, 1'b1);
        applyStimulus(5,  N,     R,     R, 2'd1, 1'b1);
        applyStimulus(6,  N,     U | R, U, 2'd1, 1'b0);
        applyStimulus(7,  R,     U | R, R, 2'd1, 1'b0);
        applyStimulus(8,  N,     R,     R, 2'd1, 1'b0);
        applyStimulus(9,  U,     R,     R, 2'd1, 1'b1);
        applyStimulus(10, N,     R,     R, 2'd1, 1'b1);
        applyStimulus(11, N,     R,     R, 2'd1, 1'b0);
        applyStimulus(12, N,     U | R, R, 2'd1, 1'b0);
        applyStimulus(13, L,     L | R, L, 2'd1, 1'b0);
        applyStimulus(14, N,     L,     L, 2'd1, 1'b0);
        applyStimulus(15, N,     N,     N, 2'd2, 1'b0);
        applyStimulus(16, N,     R,     N, 2'd2, 1'b0);
        applyStimulus(17, N,     L,     L, 2'd1, 1'b0);
        applyStimulus(18, U | L, L,     L, 2'd1, 1'b1);
        applyStimulus(19, N,     U | L, U, 2'd1, 1'b0);

        // Asynchronous reset while moving, checked before the next clk edge
        #1 rst = 1'b1;
        #1 checkOutput("async_reset", N, 2'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        setInputs(N, U | D | L | R);
        waitTick();
        checkOutput("idle_after_reset", N, 2'd0, 1'b0, 1'b1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
